multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with instruction and data memories that have variable latency.
- Drives the datapath control signals per state, with parametrised ALUOp width, an optional memory-timeout trap, and a retired-instruction counter.

---
 rtl/multicycle_control_if.sv | 46 ++++
 rtl/multicycle_control.sv | 251 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: bundles the memory handshakes, the instruction word,
// the ALU zero flag and every datapath control output of the multi-cycle
// MIPS controller. The controller side is "master", the datapath/memory side
// is "slave".
interface multicycle_control_if #(
   parameter int ALUOP_W = 5,
   parameter int CNT_W   = 32
) ();

   logic [31:0]        instr;
   logic               imem_req;
   logic               imem_ready;
   logic               dmem_req;
   logic               dmem_we;
   logic               dmem_ready;
   logic               Zero;
   logic               IRWrite;
   logic               PCWrite;
   logic [1:0]         PCSrc;
   logic               RegDst;
   logic               RegWrite;
   logic               MemToReg;
   logic               ALUSrc;
   logic               ExtOp;
   logic [ALUOP_W-1:0] ALUOp;
   logic               nBranch;
   logic               trap;
   logic [1:0]         trap_cause;
   logic [CNT_W-1:0]   instr_retired;
   logic [2:0]         state;

   modport master (
      input  instr, imem_ready, dmem_ready, Zero,
      output imem_req, dmem_req, dmem_we, IRWrite, PCWrite, PCSrc, RegDst,
             RegWrite, MemToReg, ALUSrc, ExtOp, ALUOp, nBranch, trap,
             trap_cause, instr_retired, state
   );

   modport slave (
      output instr, imem_ready, dmem_ready, Zero,
      input  imem_req, dmem_req, dmem_we, IRWrite, PCWrite, PCSrc, RegDst,
             RegWrite, MemToReg, ALUSrc, ExtOp, ALUOp, nBranch, trap,
             trap_cause, instr_retired, state
   );

endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control unit. Each instruction walks
// FETCH -> DECODE -> EXEC [-> MEM] [-> WB] and the datapath controls are
// driven per state from a latched copy of opcode/funct (the IR). Memory
// handshakes may take any number of cycles; an optional wait limit turns a
// stuck memory into a sticky trap. ALUOP_W must be at least 4.
module multicycle_control #(
   parameter int ALUOP_W     = 5,
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 32
) (
   input logic                  clk,
   input logic                  rst,
   multicycle_control_if.master bus
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd7
   } state_e;

   localparam int WAIT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_ADDU = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_SUBU = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_OR   = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_LUI  = 4'd9;

   state_e            state_d, state_q;
   logic [5:0]        irOp_q, irFunct_q;
   logic [WAIT_W-1:0] waitCnt_d, waitCnt_q;
   logic              trap_d, trap_q;
   logic [1:0]        cause_d, cause_q;
   logic [CNT_W-1:0]  retired_q;
   logic              retire;
   logic              timeoutHit;

   logic              legal, isRType, isJump, isBranch, isBne;
   logic              isLoad, isStore, useImm, extSign;
   logic [3:0]        aluCode;

   logic              imemReq, dmemReq, dmemWe, irWrite, pcWrite;
   logic [1:0]        pcSrc;
   logic              regDst, regWrite, memToReg, aluSrc, extOp, nBranch;
   logic [3:0]        aluOp;

   // The wait limit is hit when this would be the MEM_TIMEOUT-th idle cycle.
   assign timeoutHit = (MEM_TIMEOUT > 0) && (waitCnt_q == WAIT_W'(TO_LAST));

   // Decode the latched opcode/funct into instruction class and ALU settings.
   always_comb begin
      legal    = 1'b1;
      isRType  = 1'b0;
      isJump   = 1'b0;
      isBranch = 1'b0;
      isBne    = 1'b0;
      isLoad   = 1'b0;
      isStore  = 1'b0;
      useImm   = 1'b0;
      extSign  = 1'b1;
      aluCode  = ALU_ADD;
      case (irOp_q)
         6'h00: begin
            isRType = 1'b1;
            case (irFunct_q)
               6'h20: aluCode = ALU_ADD;
               6'h21: begin aluCode = ALU_ADDU; extSign = 1'b0; end
               6'h22: aluCode = ALU_SUB;
               6'h23: begin aluCode = ALU_SUBU; extSign = 1'b0; end
               6'h24: aluCode = ALU_AND;
               6'h25: aluCode = ALU_OR;
               6'h2A: aluCode = ALU_SLT;
               6'h00: aluCode = ALU_SLL;
               6'h02: aluCode = ALU_SRL;
               default: legal = 1'b0;
            endcase
         end
         6'h02: isJump = 1'b1;
         6'h04: begin isBranch = 1'b1; aluCode = ALU_SUB; end
         6'h05: begin isBranch = 1'b1; isBne = 1'b1; aluCode = ALU_SUB; end
         6'h09: begin useImm = 1'b1; aluCode = ALU_ADDU; end
         6'h0A: begin useImm = 1'b1; aluCode = ALU_SLT; end
         6'h0D: begin useImm = 1'b1; aluCode = ALU_OR; extSign = 1'b0; end
         6'h0F: begin useImm = 1'b1; aluCode = ALU_LUI; end
         6'h23: begin isLoad = 1'b1; useImm = 1'b1; aluCode = ALU_ADD; end
         6'h2B: begin isStore = 1'b1; useImm = 1'b1; aluCode = ALU_ADD; end
         default: legal = 1'b0;
      endcase
   end

   // Next-state, per-state controls, trap capture and memory wait counting.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      trap_d    = trap_q;
      cause_d   = cause_q;
      retire    = 1'b0;
      imemReq   = 1'b0;
      dmemReq   = 1'b0;
      dmemWe    = 1'b0;
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      pcSrc     = 2'd0;
      regDst    = 1'b0;
      regWrite  = 1'b0;
      memToReg  = 1'b0;
      aluSrc    = 1'b0;
      extOp     = 1'b0;
      aluOp     = 4'd0;
      nBranch   = 1'b0;
      case (state_q)
         FETCH: begin
            imemReq = 1'b1;
            if (bus.imem_ready) begin
               irWrite = 1'b1;
               pcWrite = 1'b1;
               pcSrc   = 2'd0;
               state_d = DECODE;
            end else if (timeoutHit) begin
               state_d = TRAP;
               trap_d  = 1'b1;
               cause_d = 2'b10;
            end
         end
         DECODE: begin
            if (!legal) begin
               state_d = TRAP;
               trap_d  = 1'b1;
               cause_d = 2'b01;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            aluOp   = aluCode;
            aluSrc  = useImm;
            extOp   = extSign;
            nBranch = isBne;
            if (isJump) begin
               pcWrite = 1'b1;
               pcSrc   = 2'd2;
               retire  = 1'b1;
               state_d = FETCH;
            end else if (isBranch) begin
               if (bus.Zero ^ isBne) begin
                  pcWrite = 1'b1;
                  pcSrc   = 2'd1;
               end
               retire  = 1'b1;
               state_d = FETCH;
            end else if (isLoad || isStore) begin
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            aluOp   = aluCode;
            aluSrc  = useImm;
            extOp   = extSign;
            dmemReq = 1'b1;
            dmemWe  = isStore;
            if (bus.dmem_ready) begin
               if (isStore) begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = WB;
               end
            end else if (timeoutHit) begin
               state_d = TRAP;
               trap_d  = 1'b1;
               cause_d = 2'b10;
            end
         end
         WB: begin
            aluOp    = aluCode;
            aluSrc   = useImm;
            extOp    = extSign;
            regWrite = 1'b1;
            memToReg = isLoad;
            regDst   = isRType;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         default: begin
            state_d = TRAP;
         end
      endcase
      if (state_d != state_q) begin
         waitCnt_d = '0;
      end else if (state_q == FETCH || state_q == MEM) begin
         waitCnt_d = waitCnt_q + WAIT_W'(1);
      end
   end

   // State, IR, wait counter, trap flags and retire counter; reset clears all.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         irOp_q    <= '0;
         irFunct_q <= '0;
         waitCnt_q <= '0;
         trap_q    <= 1'b0;
         cause_q   <= 2'b00;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         trap_q    <= trap_d;
         cause_q   <= cause_d;
         if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
         end
         if (irWrite) begin
            irOp_q    <= bus.instr[31:26];
            irFunct_q <= bus.instr[5:0];
         end
      end
   end

   // While reset is held every output reads as zero, dropping any request.
   assign bus.imem_req      = rst ? 1'b0 : imemReq;
   assign bus.dmem_req      = rst ? 1'b0 : dmemReq;
   assign bus.dmem_we       = rst ? 1'b0 : dmemWe;
   assign bus.IRWrite       = rst ? 1'b0 : irWrite;
   assign bus.PCWrite       = rst ? 1'b0 : pcWrite;
   assign bus.PCSrc         = rst ? 2'd0 : pcSrc;
   assign bus.RegDst        = rst ? 1'b0 : regDst;
   assign bus.RegWrite      = rst ? 1'b0 : regWrite;
   assign bus.MemToReg      = rst ? 1'b0 : memToReg;
   assign bus.ALUSrc        = rst ? 1'b0 : aluSrc;
   assign bus.ExtOp         = rst ? 1'b0 : extOp;
   assign bus.ALUOp         = rst ? '0 : ALUOP_W'(aluOp);
   assign bus.nBranch       = rst ? 1'b0 : nBranch;
   assign bus.trap          = rst ? 1'b0 : trap_q;
   assign bus.trap_cause    = rst ? 2'b00 : cause_q;
   assign bus.instr_retired = rst ? '0 : retired_q;
   assign bus.state         = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench. The stimulus process plays whole
// instructions cycle by cycle and, for each cycle, pushes the outputs the
// instruction-level reference model predicts. A monitor samples the DUT on
// every falling edge and pops/compares one expectation per cycle.
module tb_multicycle_control;

   localparam int ALUOP_W     = 5;
   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 4;

   localparam int C_ALU = 0;
   localparam int C_J   = 1;
   localparam int C_BEQ = 2;
   localparam int C_BNE = 3;
   localparam int C_LW  = 4;
   localparam int C_SW  = 5;

   typedef struct packed {
      logic [2:0]         state;
      logic               imemReq;
      logic               dmemReq;
      logic               dmemWe;
      logic               irWrite;
      logic               pcWrite;
      logic [1:0]         pcSrc;
      logic               regDst;
      logic               regWrite;
      logic               memToReg;
      logic               aluSrc;
      logic               extOp;
      logic [ALUOP_W-1:0] aluOp;
      logic               nBranch;
      logic               trap;
      logic [1:0]         trapCause;
      logic [CNT_W-1:0]   retired;
   } obs_t;

   logic clk;
   logic rst;

   multicycle_control_if #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

   multicycle_control #(
      .ALUOP_W    (ALUOP_W),
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   obs_t  expQ[$];
   string tagQ[$];
   int    testsRun    = 0;
   int    testsFailed = 0;

   int    modelRetired = 0;
   logic [1:0] modelCause = 2'b00;

   int rAlu[int];
   int iAlu[int];

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   // ALU codes by funct (R-type) and by opcode (everything else).
   task automatic fillTables();
      rAlu[32'h20] = 0; rAlu[32'h21] = 1; rAlu[32'h22] = 2; rAlu[32'h23] = 3;
      rAlu[32'h24] = 4; rAlu[32'h25] = 5; rAlu[32'h2A] = 6; rAlu[32'h00] = 7;
      rAlu[32'h02] = 8;
      iAlu[32'h02] = 0; iAlu[32'h04] = 2; iAlu[32'h05] = 2; iAlu[32'h09] = 1;
      iAlu[32'h0A] = 6; iAlu[32'h0D] = 5; iAlu[32'h0F] = 9; iAlu[32'h23] = 0;
      iAlu[32'h2B] = 0;
   endtask

   // Reference decode straight from the instruction tables.
   task automatic refDecode(input logic [31:0] w, output bit legal, output int cls,
                            output int alu, output bit ext, output bit src);
      int op;
      int fn;
      op    = int'(w[31:26]);
      fn    = int'(w[5:0]);
      legal = (op == 0) ? rAlu.exists(fn) : iAlu.exists(op);
      alu   = 0;
      if (legal) alu = (op == 0) ? rAlu[fn] : iAlu[op];
      case (op)
         32'h02:  cls = C_J;
         32'h04:  cls = C_BEQ;
         32'h05:  cls = C_BNE;
         32'h23:  cls = C_LW;
         32'h2B:  cls = C_SW;
         default: cls = C_ALU;
      endcase
      ext = !((op == 0 && (fn == 32'h21 || fn == 32'h23)) || op == 32'h0D);
      src = (op == 32'h09 || op == 32'h0A || op == 32'h0D || op == 32'h0F ||
             op == 32'h23 || op == 32'h2B);
   endtask

   function automatic obs_t base(input logic [2:0] st);
      obs_t o;
      o           = '0;
      o.state     = st;
      o.retired   = CNT_W'(modelRetired);
      o.trapCause = modelCause;
      o.trap      = (st == 3'd7);
      return o;
   endfunction

   function automatic obs_t sampleDut();
      obs_t o;
      o.state     = bus.state;
      o.imemReq   = bus.imem_req;
      o.dmemReq   = bus.dmem_req;
      o.dmemWe    = bus.dmem_we;
      o.irWrite   = bus.IRWrite;
      o.pcWrite   = bus.PCWrite;
      o.pcSrc     = bus.PCSrc;
      o.regDst    = bus.RegDst;
      o.regWrite  = bus.RegWrite;
      o.memToReg  = bus.MemToReg;
      o.aluSrc    = bus.ALUSrc;
      o.extOp     = bus.ExtOp;
      o.aluOp     = bus.ALUOp;
      o.nBranch   = bus.nBranch;
      o.trap      = bus.trap;
      o.trapCause = bus.trap_cause;
      o.retired   = bus.instr_retired;
      return o;
   endfunction

   function automatic void retireModel();
      modelRetired = (modelRetired + 1) % (1 << CNT_W);
   endfunction

   // Drive one cycle of inputs just after the rising edge and queue its expectation.
   task automatic driveCycle(input logic rstIn, input logic iRdy, input logic [31:0] word,
                             input logic dRdy, input logic zeroIn, input obs_t e,
                             input string tag);
      @(posedge clk);
      #1;
      rst            = rstIn;
      bus.imem_ready = iRdy;
      bus.instr      = word;
      bus.dmem_ready = dRdy;
      bus.Zero       = zeroIn;
      expQ.push_back(e);
      tagQ.push_back(tag);
   endtask

   task automatic resetCycle();
      driveCycle(1'b1, rb(), $urandom, rb(), rb(), '0, "reset");
      modelRetired = 0;
      modelCause   = 2'b00;
   endtask

   task automatic trapHold(input int n);
      for (int i = 0; i < n; i++) begin
         driveCycle(1'b0, rb(), $urandom, rb(), rb(), base(3'd7), "trap-hold");
      end
   endtask

   // Play one instruction: fWait/mWait idle cycles before each ready,
   // rstAt >= 0 aborts with reset at that MEM cycle.
   task automatic applyStimulus(input logic [31:0] w, input int fWait, input int mWait,
                                input logic zeroIn, input int rstAt, output bit trapped);
      bit   legal, ext, src, timedOut;
      int   cls, alu, nWait;
      obs_t e;
      trapped = 1'b0;
      refDecode(w, legal, cls, alu, ext, src);

      timedOut = (MEM_TIMEOUT > 0) && (fWait >= MEM_TIMEOUT);
      nWait    = timedOut ? MEM_TIMEOUT : fWait;
      for (int i = 0; i < nWait; i++) begin
         e = base(3'd0);
         e.imemReq = 1'b1;
         driveCycle(1'b0, 1'b0, $urandom, rb(), rb(), e, "fetch-wait");
      end
      if (timedOut) begin
         modelCause = 2'b10;
         trapped    = 1'b1;
         return;
      end
      e = base(3'd0);
      e.imemReq = 1'b1;
      e.irWrite = 1'b1;
      e.pcWrite = 1'b1;
      driveCycle(1'b0, 1'b1, w, rb(), rb(), e, "fetch");

      driveCycle(1'b0, rb(), $urandom, rb(), rb(), base(3'd1), "decode");
      if (!legal) begin
         modelCause = 2'b01;
         trapped    = 1'b1;
         return;
      end

      e = base(3'd2);
      e.aluOp   = ALUOP_W'(alu);
      e.aluSrc  = src;
      e.extOp   = ext;
      e.nBranch = (cls == C_BNE);
      if (cls == C_J) begin
         e.pcWrite = 1'b1;
         e.pcSrc   = 2'd2;
      end
      if ((cls == C_BEQ || cls == C_BNE) && (zeroIn ^ (cls == C_BNE))) begin
         e.pcWrite = 1'b1;
         e.pcSrc   = 2'd1;
      end
      driveCycle(1'b0, rb(), $urandom, rb(), zeroIn, e, "exec");
      if (cls == C_J || cls == C_BEQ || cls == C_BNE) begin
         retireModel();
         return;
      end

      if (cls == C_LW || cls == C_SW) begin
         timedOut = (MEM_TIMEOUT > 0) && (mWait >= MEM_TIMEOUT);
         nWait    = timedOut ? MEM_TIMEOUT : mWait;
         for (int i = 0; i < nWait; i++) begin
            if (i == rstAt) begin
               resetCycle();
               return;
            end
            e = base(3'd3);
            e.aluOp   = ALUOP_W'(alu);
            e.aluSrc  = src;
            e.extOp   = ext;
            e.dmemReq = 1'b1;
            e.dmemWe  = (cls == C_SW);
            driveCycle(1'b0, rb(), $urandom, 1'b0, rb(), e, "mem-wait");
         end
         if (timedOut) begin
            modelCause = 2'b10;
            trapped    = 1'b1;
            return;
         end
         e = base(3'd3);
         e.aluOp   = ALUOP_W'(alu);
         e.aluSrc  = src;
         e.extOp   = ext;
         e.dmemReq = 1'b1;
         e.dmemWe  = (cls == C_SW);
         driveCycle(1'b0, rb(), $urandom, 1'b1, rb(), e, "mem");
         if (cls == C_SW) begin
            retireModel();
            return;
         end
      end

      e = base(3'd4);
      e.aluOp    = ALUOP_W'(alu);
      e.aluSrc   = src;
      e.extOp    = ext;
      e.regWrite = 1'b1;
      e.memToReg = (cls == C_LW);
      e.regDst   = (w[31:26] == 6'h00);
      driveCycle(1'b0, rb(), $urandom, rb(), rb(), e, "wb");
      retireModel();
   endtask

   function automatic logic [31:0] randInstr(input bit wantIllegal);
      logic [5:0]  okOps  [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0D, 6'h0F, 6'h23, 6'h2B};
      logic [5:0]  okFn   [9]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
      logic [5:0]  badOps [5]  = '{6'h08, 6'h0C, 6'h3F, 6'h20, 6'h01};
      logic [5:0]  badFn  [4]  = '{6'h26, 6'h27, 6'h03, 6'h08};
      logic [31:0] w;
      w = $urandom;
      if (wantIllegal) begin
         if (rb()) begin
            w[31:26] = 6'h00;
            w[5:0]   = badFn[$urandom_range(3, 0)];
         end else begin
            w[31:26] = badOps[$urandom_range(4, 0)];
         end
      end else begin
         w[31:26] = okOps[$urandom_range(9, 0)];
         if (w[31:26] == 6'h00) w[5:0] = okFn[$urandom_range(8, 0)];
      end
      return w;
   endfunction

   task automatic checkOutput(input obs_t act, input obs_t e, input string tag);
      testsRun++;
      if (act !== e) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h (state %0d retired %0d), expected %h (state %0d retired %0d)",
                  tag, act, act.state, act.retired, e, e.state, e.retired);
      end
   endtask

   // Monitor: one queued expectation is compared on each falling edge.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(sampleDut(), expQ.pop_front(), tagQ.pop_front());
      end
   end

   // Directed sequences first, then random instructions, then drain and report.
   initial begin
      bit          tr;
      bit          ill;
      logic [31:0] w;
      fillTables();
      rst            = 1'b1;
      bus.instr      = '0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      bus.Zero       = 1'b0;
      resetCycle();
      resetCycle();

      applyStimulus(32'h00221821, 0, 0, 1'b0, -1, tr);
      applyStimulus(32'h8C220004, 1, 3, 1'b0, -1, tr);
      applyStimulus(32'h14220003, 0, 0, 1'b0, -1, tr);
      applyStimulus(32'h14220003, 0, 0, 1'b1, -1, tr);
      applyStimulus(32'h10220003, 0, 0, 1'b1, -1, tr);
      applyStimulus(32'h10220003, 2, 0, 1'b0, -1, tr);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(32'h08000000, $urandom_range(2, 0), 0, rb(), -1, tr);
      end

      applyStimulus(32'hAC220004, 0, 20, 1'b0, -1, tr);
      trapHold(10);
      resetCycle();

      applyStimulus(32'hFC000000, 0, 0, 1'b0, -1, tr);
      trapHold(10);
      resetCycle();

      applyStimulus(32'hAC220004, 0, 3, 1'b0, -1, tr);
      applyStimulus(32'h3C010005, 3, 0, 1'b0, -1, tr);

      applyStimulus(32'h00221821, 7, 0, 1'b0, -1, tr);
      trapHold(3);
      resetCycle();

      for (int n = 0; n < 40; n++) begin
         ill = ($urandom_range(7, 0) == 0);
         w   = randInstr(ill);
         applyStimulus(w, $urandom_range(3, 0), $urandom_range(3, 0), rb(), -1, tr);
         if (tr) begin
            trapHold(3);
            resetCycle();
         end
      end

      applyStimulus(32'h00221821, 0, 0, 1'b0, -1, tr);
      applyStimulus(32'hAC220004, 0, 5, 1'b0, 2, tr);
      applyStimulus(32'h00221821, 0, 0, 1'b0, -1, tr);

      for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
